// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - processor data-memory strobes plus preload handshake
// Purpose: bundles the processor-side data-memory bus (CEN/WEN/OEN/A/Data2Mem/ReadDataMem)
//          and the valid/ready preload port into one interface.
// Ports:   master = processor/bench side, slave = data_mem_responder side.
interface data_mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic              CEN;
    logic              WEN;
    logic              OEN;
    logic [ADDR_W-1:0] A;
    logic [DATA_W-1:0] Data2Mem;
    logic [DATA_W-1:0] ReadDataMem;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_bad_par;

    modport master (
        output CEN, WEN, OEN, A, Data2Mem,
        output ld_valid, ld_addr, ld_data, ld_bad_par,
        input  ReadDataMem, ld_ready
    );

    modport slave (
        input  CEN, WEN, OEN, A, Data2Mem,
        input  ld_valid, ld_addr, ld_data, ld_bad_par,
        output ReadDataMem, ld_ready
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-cycle data-memory responder with posted write buffer
// Purpose: 2**ADDR_W x DATA_W word array answering processor reads combinationally, with a
//          one-entry posted write buffer (load forwarding), a post-reset clear sequencer and a
//          valid/ready preload port. Optional parity: define DMEM_PARITY_EN.
// Ports:   clk, rst (sync, active-high); bus (slave modport: strobes, address, data, preload);
//          init_done, rd_cnt, wr_cnt, access_err, par_err status outputs.
module data_mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus,
    output logic                 init_done,
    output logic [15:0]          rd_cnt,
    output logic [15:0]          wr_cnt,
    output logic                 access_err,
    output logic                 par_err
);
    localparam int DEPTH = 2**ADDR_W;
`ifdef DMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {S_CLEAR, S_RUN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [MEM_W-1:0]  mem [DEPTH];

    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic              rd_en;
    logic              wr_en;
    logic              illegal;
    logic              ld_fire;
    logic              fwd;
    logic [MEM_W-1:0]  rd_word;
    logic [MEM_W-1:0]  commit_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    // Strobes are only honoured in S_RUN and never while reset is asserted, so the
    // combinational outputs read as idle during reset regardless of the held state.
    always_comb begin
        state_nxt       = state;
        rd_en           = 1'b0;
        wr_en           = 1'b0;
        illegal         = 1'b0;
        ld_fire         = 1'b0;
        bus.ld_ready    = 1'b0;
        bus.ReadDataMem = '0;
        fwd             = wb_valid && (wb_addr == bus.A);
        rd_word         = mem[bus.A];
        case (state)
            S_CLEAR: begin
                if (ptr == ADDR_W'(DEPTH - 1)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (!rst) begin
                    wr_en        = !bus.CEN && !bus.WEN;
                    rd_en        = !bus.CEN && !bus.OEN && bus.WEN;
                    illegal      = !bus.CEN && !bus.WEN && !bus.OEN;
                    bus.ld_ready = !wr_en;
                    ld_fire      = bus.ld_valid && !wr_en;
                    if (rd_en) begin
                        bus.ReadDataMem = fwd ? wb_data : rd_word[DATA_W-1:0];
                    end
                end
            end
            default: state_nxt = S_CLEAR;
        endcase
    end

    assign init_done = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (state == S_CLEAR) begin
            ptr <= ptr + 1'b1;
        end
    end

`ifdef DMEM_PARITY_EN
    logic wb_bad_par;
    // Even parity over the data; a bad-parity preload flips the stored bit.
    assign commit_word = {(^wb_data) ^ wb_bad_par, wb_data};
`else
    logic unused_ld_bad_par;
    assign unused_ld_bad_par = bus.ld_bad_par;
    assign commit_word       = wb_data;
`endif

    // Single write port: clear sequencer owns it in S_CLEAR, buffer commit otherwise.
    // A buffered entry is dropped when reset arrives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == S_CLEAR) begin
                mem[ptr] <= '0;
            end else if (wb_valid) begin
                mem[wb_addr] <= commit_word;
            end
        end
    end

    // The entry lives exactly one cycle: it commits on the edge after capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else if (wr_en) begin
            wb_valid <= 1'b1;
            wb_addr  <= bus.A;
            wb_data  <= bus.Data2Mem;
        end else if (ld_fire) begin
            wb_valid <= 1'b1;
            wb_addr  <= bus.ld_addr;
            wb_data  <= bus.ld_data;
        end else begin
            wb_valid <= 1'b0;
        end
    end

`ifdef DMEM_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_bad_par <= 1'b0;
        end else if (wr_en) begin
            wb_bad_par <= 1'b0;
        end else if (ld_fire) begin
            wb_bad_par <= bus.ld_bad_par;
        end
    end

    // Forwarded data never touched the array, so only array reads are checked.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (rd_en && !fwd && (^rd_word)) begin
            par_err <= 1'b1;
        end
    end
`else
    assign par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            access_err <= 1'b0;
        end else begin
            if (rd_en && (rd_cnt != 16'hFFFF)) begin
                rd_cnt <= rd_cnt + 16'd1;
            end
            if (wr_en && (wr_cnt != 16'hFFFF)) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (illegal) begin
                access_err <= 1'b1;
            end
        end
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the processor's data-memory interface: decodes the active-low CEN/WEN/OEN strobes, word address A and Data2Mem, and returns ReadDataMem in the same cycle, as the single-cycle datapath requires. The block owns a 128 x 32 word array. Writes are posted through a one-entry write buffer with load forwarding. A post-reset clear sequencer zeroes the array, and a valid/ready preload port lets the bench fill memory before the processor runs.

## Interface
- DATA_W, 32, word width
- ADDR_W, 7, word address width; depth = 2**ADDR_W
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- CEN  in  1  chip enable, active-low
- WEN  in  1  write enable, active-low
- OEN  in  1  output (read) enable, active-low
- A  in  ADDR_W  word address
- Data2Mem  in  DATA_W  write data
- ReadDataMem  out  DATA_W  read data, combinational
- ld_valid  in  1  preload request
- ld_ready  out  1  preload accepted this cycle
- ld_addr  in  ADDR_W  preload address
- ld_data  in  DATA_W  preload data
- ld_bad_par  in  1  store inverted parity for this preload (parity build only)
- init_done  out  1  clear sequence finished
- rd_cnt  out  16  processor read count, saturating
- wr_cnt  out  16  processor write count, saturating
- access_err  out  1  sticky illegal-strobe flag
- par_err  out  1  sticky parity-error flag

## Operation
- Reset values: init_done=0, ld_ready=0, rd_cnt=0, wr_cnt=0, access_err=0, par_err=0, write buffer invalid, clear pointer=0. ReadDataMem=0 while reset is held.
- FSM S_CLEAR: the array is not cleared by reset itself. The sequencer writes 0 to address ptr each cycle and increments ptr. After address 2**ADDR_W-1 it moves to S_RUN.
- In S_CLEAR: ReadDataMem=0, ld_ready=0, processor strobes ignored, counters held.
- In S_RUN: init_done=1.
- Strobe decode, S_RUN only:
  - Read: CEN=0, OEN=0, WEN=1.
  - Write: CEN=0, WEN=0.
  - CEN=0 with WEN=0 and OEN=0: treated as a write; sets access_err.
  - CEN=1, or CEN=0 with WEN=1 and OEN=1: no-op.
- Read data:
  - If the buffer is valid and wb_addr==A, ReadDataMem=wb_data (forwarding).
  - Otherwise ReadDataMem=array[A].
  - ReadDataMem=0 when no read is decoded.
- Write buffer (one entry):
  - A processor write captures {A, Data2Mem} at the clock edge.
  - Any valid entry commits to the array at the next edge, on the same edge that a new entry is captured.
  - The array has one write port: buffer commit, or clear-sequencer write in S_CLEAR.
- Preload:
  - ld_ready = S_RUN && !(processor write this cycle).
  - On ld_valid && ld_ready the entry enters the write buffer exactly like a processor write.
  - The processor has priority; a stalled preload keeps ld_valid and holds its fields stable.
- Counters:
  - rd_cnt increments on each decoded read; wr_cnt increments on each decoded processor write.
  - Preloads are not counted.
  - Both saturate at 16'hFFFF.
- Address width: A is taken modulo depth; no out-of-range condition exists.

## Timing
- Read latency 0: ReadDataMem is valid in the same cycle as the strobes, combinationally from A/CEN/OEN and the buffer.
- A write issued in cycle N is readable in cycle N+1 (forwarded) and lands in the array at the end of N+1.
- Back-to-back writes to the same address: the newest value always wins, both for forwarding and for the final array contents.
- The clear sequence takes 2**ADDR_W cycles after the last cycle with rst=1; init_done rises on the following edge (cycle 129 at default).
- Reset mid-operation: on the next edge the FSM re-enters S_CLEAR, the buffer entry is discarded (not committed), and counters and sticky flags clear.
- access_err and par_err stay high until rst.

## Configuration
- DMEM_PARITY_EN defined:
  - The array stores DATA_W+1 bits per word, with even parity over the data.
  - A preload with ld_bad_par=1 stores the inverted parity bit.
  - A read returning an array word with a parity mismatch sets par_err; forwarded buffer data is not checked.
  - Clear writes a correct parity bit.
- DMEM_PARITY_EN undefined: the array is DATA_W wide, ld_bad_par is ignored, and par_err is tied 0.

## Test plan
- Clear: rst high 2 cycles, then low. init_done=0 for 128 cycles and 1 after. A read of A=7'h55 returns 0, with access_err=0 and par_err=0.
- Forwarding: write 0xDEADBEEF to A=3 in cycle N.
  - Read A=3 in N+1 -> 0xDEADBEEF (from the buffer).
  - Read A=3 in N+5 -> 0xDEADBEEF (from the array).
  - wr_cnt=1, rd_cnt=2.
- Same-address overwrite: writes 0x11 then 0x22 to A=9 on consecutive cycles; the next read of A=9 returns 0x22, and later reads also return 0x22.
- Preload arbitration: hold ld_valid with ld_addr=5, ld_data=0xA5A5A5A5 while the processor writes 0x1 to A=6. ld_ready=0 that cycle and 1 the next. Afterwards A=5 reads 0xA5A5A5A5 and A=6 reads 0x1.
- Illegal strobes: CEN=0, WEN=0, OEN=0, A=2, Data2Mem=0x7. access_err goes to 1, A=2 then reads 0x7, and access_err stays set until rst.
- Parity (DMEM_PARITY_EN): preload A=4 with ld_bad_par=1. A read of A=4 sets par_err=1; without the macro, the same stimulus leaves par_err=0.
